if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage feeding the IF/ID pipeline register and the decode stage. Holds the architectural fetch PC, runs a single-outstanding request/response handshake to instruction memory, and applies branch/jump redirects from decode with MIPS delay-slot semantics. Applies exception/ERET flushes from the CP0 path and delivers one instruction per accepted fetch, with PC and PC+4, to decode.

## Interface
- RESET_PC, 32'hBFC0_0000, fetch address after reset
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- if_stall_i  in  1  hazard unit holds IF/ID and ID; no delivery, no redirect capture
- flush_i  in  1  exception/ERET flush, highest priority
- flush_pc_i  in  32  new fetch PC on flush
- id_redirect_i  in  1  decode resolved taken branch / j / jal / jr / jalr
- id_target_i  in  32  redirect target from decode
- inst_req_o  out  1  request valid
- inst_addr_o  out  32  request address (= fetch PC)
- inst_addr_ok_i  in  1  request accepted this cycle
- inst_data_ok_i  in  1  response valid this cycle
- inst_rdata_i  in  32  response word
- id_valid_o  out  1  IF/ID holds a real instruction
- id_instr_o  out  32  instruction to decode
- id_pc_o  out  32  its PC
- id_pc4_o  out  32  its PC+4
- id_adel_o  out  1  instruction-fetch address error (PC[1:0]≠0)
- if_busy_o  out  1  no instruction deliverable this cycle

## Operation
- States: REQ (request pending), WAIT (accepted, awaiting data), HOLD (word buffered, decode stalled), DISCARD (drop in-flight response after flush).
- REQ: inst_req_o=1, inst_addr_o=pc. If pc[1:0]≠0: no request (inst_req_o=0); deliverable immediately as instr 0, adel=1. Else addr_ok → WAIT.
- WAIT: data_ok & !if_stall_i → deliver, → REQ. data_ok & if_stall_i → buffer word, → HOLD.
- HOLD: !if_stall_i → deliver buffer, → REQ.
- DISCARD: data_ok → REQ; word dropped.
- Deliver: IF/ID register loads valid=1, instr, pc, pc+4, adel. Fetch pc then becomes pend_addr if a redirect is pending (or captured that cycle), else pc+4. Pending is cleared.
- IF/ID update when !if_stall_i and nothing deliverable: valid=0 (bubble), instr=0, adel=0; pc fields hold. if_stall_i=1: IF/ID holds.
- Redirect capture: id_redirect_i & !if_stall_i → pend_valid=1, pend_addr=id_target_i. A second capture overwrites. The instruction after the branch (delay slot) is always the next delivered instruction; the target follows it.
- Flush (any state): pc←flush_pc_i, pend_valid←0, IF/ID valid←0, buffer dropped. Next state:
  - WAIT → DISCARD, unless data_ok arrives the same cycle → REQ.
  - REQ with addr_ok the same cycle → DISCARD.
  - REQ without addr_ok, or HOLD → REQ.
  - DISCARD → DISCARD, unless data_ok the same cycle → REQ.
- Flush beats redirect and delivery in the same cycle.
- inst_addr_o may change while unaccepted (REQ only). It is stable from acceptance until data_ok.
- if_busy_o = !(HOLD | (WAIT & data_ok) | (REQ & pc[1:0]≠0)).
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset (async assert): state=REQ, pc=RESET_PC, pend_valid=0, id_valid_o=0, id_instr_o=0, id_pc_o=0, id_pc4_o=0, id_adel_o=0. inst_req_o=1 combinationally from the first cycle after release.
- Zero-wait memory (addr_ok cycle N, data_ok N+1): id_valid_o high from N+2; next request issued in N+2. Peak throughput is 1 instruction / 2 cycles.
- Reset mid-transaction: state forced to REQ; any late data_ok is ignored by the reset state machine. The memory side is reset by the same rst_i.
- A redirect captured in the delivery cycle of the delay slot takes effect on the very next request address.

## Test plan
- Reset release, memory returning PC as data, zero-wait: inst_addr_o = BFC00000, BFC00004, BFC00008; id_instr_o/id_pc_o match; id_pc4_o = id_pc_o+4.
- Branch resolved in decode at delivery cycle of BFC00004 (target BFC00100): delivered sequence BFC00000, BFC00004 (delay slot), BFC00100.
- Redirect while delay-slot fetch is in WAIT with 3-cycle memory latency: delay slot BFC00008 delivered after a bubble, then target; no BFC0000C request ever issued.
- flush_i (flush_pc_i=BFC00380) while in WAIT: in-flight word never reaches id_valid_o; next request is BFC00380 after data_ok; pending redirect cleared.
- if_stall_i held 4 cycles while data_ok arrives: word held in HOLD, IF/ID unchanged; delivered exactly once on stall release, no re-request.
- Redirect to BFC00102: no request issued, id_valid_o=1, id_adel_o=1, id_instr_o=0, id_pc_o=BFC00102; a following flush recovers fetch.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// request/response handshake to instruction memory, applies decode redirects
// with delay-slot semantics and CP0 flushes, and loads the IF/ID register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        id_redirect_i,
  input  logic [31:0] id_target_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic        id_adel_o,
  output logic        if_busy_o
);

  typedef enum logic [1:0] {
    S_REQ,     // request pending at the current pc
    S_WAIT,    // request accepted, awaiting the response word
    S_HOLD,    // response word buffered while decode is stalled
    S_DISCARD  // drop the in-flight response of a flushed fetch
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc_plus4;
  logic        pend_valid, pend_valid_nxt;
  logic [31:0] pend_addr, pend_addr_nxt;
  logic [31:0] hold_word;

  logic        misaligned;
  logic        deliverable;
  logic        deliver;
  logic        capture;
  logic        load_hold;
  logic [31:0] dlv_instr;
  logic        dlv_adel;

  assign misaligned = (pc[1:0] != 2'b00);
  assign pc_plus4   = pc + 32'd4;

  // A misaligned pc never reaches memory; it is delivered as an address error.
  assign inst_req_o  = (state == S_REQ) && !misaligned;
  assign inst_addr_o = pc;

  assign deliverable = (state == S_HOLD)
                     || ((state == S_WAIT) && inst_data_ok_i)
                     || ((state == S_REQ) && misaligned);
  assign if_busy_o   = !deliverable;

  // Flush outranks both delivery and redirect capture in the same cycle.
  assign deliver   = deliverable && !if_stall_i && !flush_i;
  assign capture   = id_redirect_i && !if_stall_i && !flush_i;
  assign load_hold = (state == S_WAIT) && inst_data_ok_i && if_stall_i && !flush_i;

  // Select the word handed to decode according to where it currently lives.
  always_comb begin
    dlv_instr = 32'd0;
    dlv_adel  = 1'b0;
    case (state)
      S_HOLD:  dlv_instr = hold_word;
      S_WAIT:  dlv_instr = inst_rdata_i;
      S_REQ:   dlv_adel  = misaligned;
      default: dlv_instr = 32'd0;
    endcase
  end

  // Next-state, next-pc and pending-redirect logic.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    state_nxt      = state;
    pc_nxt         = pc;
    pend_valid_nxt = pend_valid;
    pend_addr_nxt  = pend_addr;

    if (flush_i) begin
      pc_nxt         = flush_pc_i;
      pend_valid_nxt = 1'b0;
      case (state)
        S_REQ:     state_nxt = (inst_req_o && inst_addr_ok_i) ? S_DISCARD : S_REQ;
        S_WAIT:    state_nxt = inst_data_ok_i ? S_REQ : S_DISCARD;
        S_HOLD:    state_nxt = S_REQ;
        S_DISCARD: state_nxt = inst_data_ok_i ? S_REQ : S_DISCARD;
        default:   state_nxt = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ:     if (inst_req_o && inst_addr_ok_i) state_nxt = S_WAIT;
        S_WAIT:    if (inst_data_ok_i) state_nxt = if_stall_i ? S_HOLD : S_REQ;
        S_HOLD:    if (!if_stall_i) state_nxt = S_REQ;
        S_DISCARD: if (inst_data_ok_i) state_nxt = S_REQ;
        default:   state_nxt = S_REQ;
      endcase

      // The delivered instruction is the delay slot; the redirect target
      // (pending, or captured this very cycle) is fetched right after it.
      if (deliver) begin
        if (capture)         pc_nxt = id_target_i;
        else if (pend_valid) pc_nxt = pend_addr;
        else                 pc_nxt = pc_plus4;
        pend_valid_nxt = 1'b0;
      end else if (capture) begin
        pend_valid_nxt = 1'b1;
        pend_addr_nxt  = id_target_i;
      end
    end
  end

  // Fetch control state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (!rst_i) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_addr  <= 32'd0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend_valid <= pend_valid_nxt;
      pend_addr  <= pend_addr_nxt;
    end
  end

  // Buffer the response word when decode is stalled at arrival.
  always_ff @(posedge clk_i) begin
    // NOTE: pure datapath buffer, no reset; it is only read in S_HOLD, which
    // can only be entered after it has been written.
    if (load_hold) hold_word <= inst_rdata_i;
  end

  // IF/ID pipeline register: deliver, insert a bubble, or hold under stall.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      id_valid_o <= 1'b0;
      id_instr_o <= 32'd0;
      id_pc_o    <= 32'd0;
      id_pc4_o   <= 32'd0;
      id_adel_o  <= 1'b0;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
    end else if (!if_stall_i) begin
      if (deliver) begin
        id_valid_o <= 1'b1;
        id_instr_o <= dlv_instr;
        id_pc_o    <= pc;
        id_pc4_o   <= pc_plus4;
        id_adel_o  <= dlv_adel;
      end else begin
        id_valid_o <= 1'b0;
        id_instr_o <= 32'd0;
        id_adel_o  <= 1'b0;
      end
    end
  end

endmodule
